// File: rtl/full_sub.sv
// rtl/full_sub.sv - ripple-borrow full subtractor with combinational and registered results
module full_sub #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             Bin,
    input  logic             in_valid,
    output logic [WIDTH-1:0] diff,
    output logic             Bout,
    output logic [WIDTH-1:0] diff_r,
    output logic             Bout_r,
    output logic             out_valid
);

    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
    logic             valid_q, valid_d;

    // Borrow ripples LSB to MSB through a loop-local variable, one cell per bit.
    always_comb begin
        logic bi;
        bi   = Bin;
        diff = '0;
        for (int i = 0; i < WIDTH; i++) begin
            diff[i] = a[i] ^ b[i] ^ bi;
            bi      = (~a[i] & b[i]) | (bi & ~(a[i] ^ b[i]));
        end
        Bout = bi;
    end

    always_comb begin
        diff_d  = diff_q;
        bout_d  = bout_q;
        valid_d = 1'b0;
        if (in_valid) begin
            diff_d  = diff;
            bout_d  = Bout;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            diff_q  <= '0;
            bout_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            valid_q <= valid_d;
        end
    end

    assign diff_r    = diff_q;
    assign Bout_r    = bout_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_full_sub.sv
// tb/tb_full_sub.sv - self-checking bench for full_sub at WIDTH=1 and WIDTH=8
module tb_full_sub;

    logic       clk;
    logic       clk_run;
    logic       rst;

    logic       a1, b1, bin1, iv1;
    logic       d1, bo1, dr1, bor1, ov1;

    logic [7:0] a8, b8;
    logic       bin8, iv8;
    logic [7:0] d8, dr8;
    logic       bo8, bor8, ov8;

    int errors;
    int checks;

    full_sub #(.WIDTH(1)) u_w1 (
        .clk(clk), .rst(rst), .a(a1), .b(b1), .Bin(bin1), .in_valid(iv1),
        .diff(d1), .Bout(bo1), .diff_r(dr1), .Bout_r(bor1), .out_valid(ov1)
    );

    full_sub #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst(rst), .a(a8), .b(b8), .Bin(bin8), .in_valid(iv8),
        .diff(d8), .Bout(bo8), .diff_r(dr8), .Bout_r(bor8), .out_valid(ov8)
    );

    initial begin
        clk = 1'b0;
        forever begin
            #5;
            if (clk_run) clk = ~clk;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: unsigned subtraction widened by one bit; the top bit is the borrow.
    function automatic logic [8:0] ref_sub8(input logic [7:0] a, input logic [7:0] b, input logic bin);
        return ({1'b0, a} - {1'b0, b} - {8'd0, bin});
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] tbl_diff;
        logic [7:0] tbl_bout;
        logic [8:0] r;
        logic [7:0] exp_dr;
        logic       exp_bor;
        errors   = 0;
        checks   = 0;
        tbl_diff = 8'b1001_0110;
        tbl_bout = 8'b1000_1110;
        clk_run  = 1'b0;
        rst      = 1'b1;
        {a1, b1, bin1, iv1} = 4'b0;
        a8 = 8'h00; b8 = 8'h00; bin8 = 1'b0; iv8 = 1'b0;
        #2;
        check("rst_w1_diff_r", 64'(dr1), 64'd0);
        check("rst_w1_bout_r", 64'(bor1), 64'd0);
        check("rst_w1_valid", 64'(ov1), 64'd0);
        check("rst_w8_diff_r", 64'(dr8), 64'd0);
        check("rst_w8_valid", 64'(ov8), 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = 3'(i);
            {a1, b1, bin1} = v;
            #10;
            check($sformatf("w1_diff_%0d", i), 64'(d1), 64'(tbl_diff[i]));
            check($sformatf("w1_bout_%0d", i), 64'(bo1), 64'(tbl_bout[i]));
        end

        {a1, b1, bin1} = 3'b011;
        iv1 = 1'b1;
        #20;
        check("w1_stopped_diff", 64'(d1), 64'd0);
        check("w1_stopped_bout", 64'(bo1), 64'd1);
        check("w1_stopped_diff_r", 64'(dr1), 64'd0);
        check("w1_stopped_bout_r", 64'(bor1), 64'd0);
        check("w1_stopped_valid", 64'(ov1), 64'd0);
        iv1 = 1'b0;

        clk_run = 1'b1;
        tick();
        a8 = 8'h00; b8 = 8'hFF; bin8 = 1'b1; iv8 = 1'b1;
        #1;
        check("w8_wrap_diff", 64'(d8), 64'h00);
        check("w8_wrap_bout", 64'(bo8), 64'd1);
        tick();
        check("w8_wrap_diff_r", 64'(dr8), 64'h00);
        check("w8_wrap_bout_r", 64'(bor8), 64'd1);
        check("w8_wrap_valid", 64'(ov8), 64'd1);

        iv8 = 1'b0;
        a8 = 8'h5A; b8 = 8'h5A; bin8 = 1'b1;
        #1;
        check("w8_eq_bin1_diff", 64'(d8), 64'hFF);
        check("w8_eq_bin1_bout", 64'(bo8), 64'd1);
        bin8 = 1'b0;
        #1;
        check("w8_eq_bin0_diff", 64'(d8), 64'h00);
        check("w8_eq_bin0_bout", 64'(bo8), 64'd0);

        tick();
        a8 = 8'd10; b8 = 8'd3; bin8 = 1'b0; iv8 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("b2b_diff_r_%0d", k), 64'(dr8), 64'd7);
            check($sformatf("b2b_bout_r_%0d", k), 64'(bor8), 64'd0);
            check($sformatf("b2b_valid_%0d", k), 64'(ov8), 64'd1);
        end
        iv8 = 1'b0;
        tick();
        check("b2b_idle_valid", 64'(ov8), 64'd0);
        check("b2b_idle_hold", 64'(dr8), 64'd7);

        iv8 = 1'b1;
        tick();
        check("pre_rst_valid", 64'(ov8), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_diff_r", 64'(dr8), 64'd0);
        check("async_rst_bout_r", 64'(bor8), 64'd0);
        check("async_rst_valid", 64'(ov8), 64'd0);
        tick();
        check("rst_wins_diff_r", 64'(dr8), 64'd0);
        check("rst_wins_valid", 64'(ov8), 64'd0);
        rst = 1'b0;
        tick();
        check("post_rst_diff_r", 64'(dr8), 64'd7);
        check("post_rst_valid", 64'(ov8), 64'd1);

        exp_dr  = 8'd7;
        exp_bor = 1'b0;
        for (int n = 0; n < 200; n++) begin
            a8   = 8'($urandom);
            b8   = 8'($urandom);
            bin8 = 1'($urandom);
            iv8  = 1'($urandom);
            r    = ref_sub8(a8, b8, bin8);
            #1;
            check("rand_diff", 64'(d8), 64'(r[7:0]));
            check("rand_bout", 64'(bo8), 64'(r[8]));
            if (iv8) begin
                exp_dr  = r[7:0];
                exp_bor = r[8];
            end
            tick();
            check("rand_diff_r", 64'(dr8), 64'(exp_dr));
            check("rand_bout_r", 64'(bor8), 64'(exp_bor));
            check("rand_valid", 64'(ov8), 64'(iv8));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
